// File: rtl/fifo_pkg.sv
// Definitions shared by the byte FIFO, its write-side producer and the read-side serializer.
package fifo_pkg;

    localparam int FIFO_DATA_W = 8;
    localparam int FIFO_DEPTH  = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        POP   = 3'd1,
        CAP   = 3'd2,
        START = 3'd3,
        DATA  = 3'd4,
        STOP  = 3'd5
    } ser_state_t;

endpackage

// File: rtl/bit_tick_gen.sv
// Serial bit-period divider: one-cycle tick on the last clock of every bit period.
module bit_tick_gen #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/fifo_rd_serializer.sv
// Pops bytes from the FIFO read port and shifts them out LSB first with start/stop framing.
module fifo_rd_serializer
    import fifo_pkg::*;
#(
    parameter int DATA_W       = FIFO_DATA_W,
    parameter int CLKS_PER_BIT = 4,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              nostock,
    input  logic [DATA_W-1:0] dout,
    output logic              rd,
    output logic              txd,
    output logic              busy,
    output logic [15:0]       frame_cnt,
    output logic [2:0]        dbg_state
);

    localparam int BW = $clog2(DATA_W + 1);

    ser_state_t        state_q, state_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic              rd_q, rd_d;
    logic              txd_q, txd_d;
    logic              busy_q, busy_d;
    logic              tick;
    logic              tick_clr;

    // FIFO read contract: rd is a one-cycle pop issued only while nostock is low;
    // dout holds the popped byte in the cycle after rd, so it is captured in CAP.
    assign tick_clr = (state_q == IDLE) || (state_q == POP) || (state_q == CAP);

    bit_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tick (
        .clk   (clk),
        .rst   (rst),
        .clr_i (tick_clr),
        .tick_o(tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            frame_cnt_q <= '0;
            rd_q        <= 1'b0;
            txd_q       <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            frame_cnt_q <= frame_cnt_d;
            rd_q        <= rd_d;
            txd_q       <= txd_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            IDLE: if (en && !nostock) state_d = POP;
            POP:  state_d = CAP;
            CAP: begin
                shreg_d   = dout;
                bit_cnt_d = '0;
                state_d   = START;
            end
            START: if (tick) begin
                bit_cnt_d = '0;
                state_d   = DATA;
            end
            DATA: if (tick) begin
                shreg_d = shreg_q >> 1;
                if (bit_cnt_q == BW'(DATA_W - 1)) begin
                    bit_cnt_d = '0;
                    state_d   = STOP;
                end else begin
                    bit_cnt_d = bit_cnt_q + BW'(1);
                end
            end
            STOP: if (tick) begin
                // bit_cnt counts stop bits here; the last one closes the frame.
                if (bit_cnt_q == BW'(STOP_BITS - 1)) begin
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    bit_cnt_d   = '0;
                    state_d     = (en && !nostock) ? POP : IDLE;
                end else begin
                    bit_cnt_d = bit_cnt_q + BW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_comb begin
        rd_d   = (state_d == POP);
        busy_d = (state_d != IDLE);
        txd_d  = 1'b1;
        if (state_d == START) begin
            txd_d = 1'b0;
        end else if (state_d == DATA) begin
            txd_d = shreg_d[0];
        end
    end

    assign rd        = rd_q;
    assign txd       = txd_q;
    assign busy      = busy_q;
    assign frame_cnt = frame_cnt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_fifo_rd_serializer.sv
// Bench for fifo_rd_serializer: timeline model of each frame, line decoder and literal pins.
module tb_fifo_rd_serializer;

  localparam int CPB = 4;
  localparam int DW = 8;
  localparam int SB = 1;
  localparam int FRAME_T = 2 + (1 + DW + SB) * CPB;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  logic en;
  always #5 clk = ~clk;

  // DUT 1 (one stop bit) and its FIFO environment
  logic nostock;
  logic [7:0] dout = 8'h00;
  logic rd, txd, busy;
  logic [15:0] frame_cnt;
  logic [2:0] dbg_state;

  logic [7:0] push_mem [0:255];
  int n_pushed = 0;
  int rd_ptr = 0;

  assign nostock = (rd_ptr == n_pushed);

  always @(posedge clk) begin
    if (rd) begin
      dout <= push_mem[rd_ptr[7:0]];
      rd_ptr <= rd_ptr + 1;
    end
  end

  fifo_rd_serializer #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(SB)) dut (
    .clk(clk), .rst(rst), .en(en), .nostock(nostock), .dout(dout),
    .rd(rd), .txd(txd), .busy(busy), .frame_cnt(frame_cnt), .dbg_state(dbg_state)
  );

  // DUT 2 (two stop bits), fed a constant byte from an always-full source
  logic rst2, en2;
  logic rd2, txd2, busy2;
  logic [15:0] frame_cnt2;
  logic [2:0] dbg_state2;
  logic [7:0] dout2 = 8'h3C;
  logic nostock2 = 1'b0;
  bit dut2_done = 0;

  fifo_rd_serializer #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst2), .en(en2), .nostock(nostock2), .dout(dout2),
    .rd(rd2), .txd(txd2), .busy(busy2), .frame_cnt(frame_cnt2), .dbg_state(dbg_state2)
  );

  // scoreboard
  int n_total = 0;
  int n_pass = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int rd_cyc_q[$];
  int lat_q[$];
  int run_q[$];
  int rd_pulses = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // model: a frame is a timeline t = 0 .. FRAME_T-1 counted from the pop cycle
  bit m_active = 0;
  int m_t = 0;
  int m_ptr = 0;
  logic [7:0] m_byte = 8'h00;
  logic [15:0] m_cnt = 16'h0000;
  logic e_rd, e_txd, e_busy;
  bit rx_on = 0;
  int rx_cnt = 0;
  int hi_run = 0;
  logic [7:0] rx_byte = 8'h00;

  initial begin : compare_proc
    bit start;
    int k;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst) begin
        if (m_active) exp_q.delete(exp_q.size() - 1);
        m_active = 0;
        m_t = 0;
        m_cnt = 16'h0000;
        rx_on = 0;
        rx_cnt = 0;
      end else begin
        start = 0;
        if (!m_active) begin
          start = en && (m_ptr != n_pushed);
        end else if (m_t == FRAME_T - 1) begin
          m_cnt = m_cnt + 16'd1;
          m_active = 0;
          start = en && (m_ptr != n_pushed);
        end else begin
          m_t++;
        end
        if (start) begin
          m_active = 1;
          m_t = 0;
          m_byte = push_mem[m_ptr[7:0]];
          m_ptr++;
          exp_q.push_back(m_byte);
        end
      end

      e_rd = m_active && (m_t == 0);
      e_busy = m_active;
      e_txd = 1'b1;
      if (m_active && m_t >= 2) begin
        k = (m_t - 2) / CPB;
        if (k == 0) e_txd = 1'b0;
        else if (k <= DW) e_txd = m_byte[k-1];
      end
      check("rd", 32'(rd), 32'(e_rd));
      check("txd", 32'(txd), 32'(e_txd));
      check("busy", 32'(busy), 32'(e_busy));
      check("frame_cnt", 32'(frame_cnt), 32'(m_cnt));

      // line decoder: recovers bytes from txd independently of the model timeline
      if (rd) begin
        rd_pulses++;
        rd_cyc_q.push_back(cyc);
      end
      if (!rst) begin
        if (!rx_on) begin
          if (txd == 1'b0) begin
            rx_on = 1;
            rx_cnt = 0;
            if (rd_cyc_q.size() > 0) lat_q.push_back(cyc - rd_cyc_q[rd_cyc_q.size()-1]);
            run_q.push_back(hi_run);
          end
        end else begin
          rx_cnt++;
          if (rx_cnt == CPB * (1 + DW) + CPB / 2) begin
            rx_on = 0;
            check("stop_bit", 32'(txd), 32'd1);
            got_q.push_back(rx_byte);
            if (exp_q.size() == 0) check("unexpected_frame", 32'(exp_q.size()), 32'd1);
            else check("rx_byte", 32'(rx_byte), 32'(exp_q.pop_front()));
          end else if (rx_cnt % CPB == CPB / 2) begin
            rx_byte = {txd, rx_byte[7:1]};
          end
        end
      end
      hi_run = txd ? hi_run + 1 : 0;
    end
  end

  // driver tasks
  task automatic push(input logic [7:0] b);
    push_mem[n_pushed[7:0]] = b;
    n_pushed++;
  endtask

  task automatic wait_cnt(input logic [15:0] target, input int budget);
    int i;
    i = 0;
    while (frame_cnt != target && i < budget) begin
      @(negedge clk);
      i++;
    end
    check("wait_frame_cnt", 32'(frame_cnt), 32'(target));
  endtask

  task automatic wait_rd(input int budget);
    int i;
    i = 0;
    @(negedge clk);
    while (!rd && i < budget) begin
      @(negedge clk);
      i++;
    end
    check("wait_rd", 32'(rd), 32'd1);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // DUT 2: stop period of two bits and back-to-back spacing
  initial begin : dut2_proc
    int hi2;
    int rd2_q[$];
    int run2_q[$];
    rst2 = 1'b0;
    en2 = 1'b0;
    #2 rst2 = 1'b1;
    hi2 = 0;
    for (int c = 0; c < 220; c++) begin
      @(posedge clk);
      #1;
      if (rd2) rd2_q.push_back(c);
      if (!txd2) begin
        if (hi2 > 0) run2_q.push_back(hi2);
        hi2 = 0;
      end else begin
        hi2++;
      end
      if (c == 2) begin
        rst2 = 1'b0;
        en2 = 1'b1;
      end
      if (c == 100) en2 = 1'b0;
    end
    check("s2_rd_pulses", 32'(rd2_q.size()), 32'd3);
    check("s2_period_a", 32'(rd2_q[1] - rd2_q[0]), 32'd46);
    check("s2_period_b", 32'(rd2_q[2] - rd2_q[1]), 32'd46);
    check("s2_data_run", 32'(run2_q[1]), 32'd16);
    check("s2_stop_gap_run", 32'(run2_q[2]), 32'd10);
    check("s2_frame_cnt", 32'(frame_cnt2), 32'd3);
    check("s2_idle_txd", 32'(txd2), 32'd1);
    check("s2_idle_busy", 32'(busy2), 32'd0);
    dut2_done = 1;
  end

  initial begin : main_proc
    int i;
    rst = 1'b0;
    en = 1'b0;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_rd", 32'(rd), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;

    // empty FIFO with en high: nothing may move
    en = 1'b1;
    repeat (100) @(negedge clk);
    check("idle_rd_pulses", 32'(rd_pulses), 32'd0);
    check("idle_frame_cnt", 32'(frame_cnt), 32'd0);

    // single byte
    push(8'hA5);
    wait_cnt(16'd1, 200);
    check("a5_byte", 32'(got_q[0]), 32'hA5);
    check("a5_latency", 32'(lat_q[0]), 32'd2);
    check("a5_rd_pulses", 32'(rd_pulses), 32'd1);
    check("a5_fifo_empty", 32'(rd_ptr), 32'(n_pushed));

    // back-to-back frames
    push(8'h01);
    push(8'hFF);
    push(8'h3C);
    wait_cnt(16'd4, 400);
    check("b2b_byte0", 32'(got_q[1]), 32'h01);
    check("b2b_byte1", 32'(got_q[2]), 32'hFF);
    check("b2b_byte2", 32'(got_q[3]), 32'h3C);
    check("b2b_period", 32'(rd_cyc_q[3] - rd_cyc_q[2]), 32'd42);
    check("b2b_stop_gap_run", 32'(run_q[2]), 32'd6);
    check("b2b_rd_pulses", 32'(rd_pulses), 32'd4);

    // en dropped mid-frame
    push(8'h55);
    push(8'h77);
    wait_rd(50);
    repeat (12) @(negedge clk);
    en = 1'b0;
    repeat (60) @(negedge clk);
    check("en_off_frame_cnt", 32'(frame_cnt), 32'd5);
    check("en_off_rd_pulses", 32'(rd_pulses), 32'd5);
    check("en_off_fifo_left", 32'(n_pushed - rd_ptr), 32'd1);
    check("en_off_busy", 32'(busy), 32'd0);
    en = 1'b1;
    wait_cnt(16'd6, 200);
    check("en_off_byte0", 32'(got_q[4]), 32'h55);
    check("en_off_byte1", 32'(got_q[5]), 32'h77);

    // reset during bit 3 of 0x96
    push(8'h96);
    push(8'h3A);
    wait_rd(50);
    repeat (19) @(negedge clk);
    check("pre_rst_txd", 32'(txd), 32'd0);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_txd", 32'(txd), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_frame_cnt", 32'(frame_cnt), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_cnt(16'd1, 200);
    check("post_rst_byte", 32'(got_q[got_q.size()-1]), 32'h3A);
    check("post_rst_count", 32'(got_q.size()), 32'd7);
    check("post_rst_latency", 32'(lat_q[lat_q.size()-1]), 32'd2);
    check("post_rst_fifo_empty", 32'(rd_ptr), 32'(n_pushed));

    // random bursts with random en toggling
    for (int b = 0; b < 6; b++) begin
      for (int j = 0; j < int'($urandom_range(1, 3)); j++) push(8'($urandom_range(0, 255)));
      i = 0;
      while (i < 120) begin
        @(negedge clk);
        if ($urandom_range(0, 15) == 0) en = ~en;
        i++;
      end
    end
    en = 1'b1;
    i = 0;
    while ((rd_ptr != n_pushed || busy) && i < 1000) begin
      @(negedge clk);
      i++;
    end
    check("rand_drained", 32'(rd_ptr), 32'(n_pushed));

    i = 0;
    while (!dut2_done && i < 1000) begin
      @(negedge clk);
      i++;
    end
    check("dut2_done", 32'(dut2_done), 32'd1);
    repeat (5) @(negedge clk);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fifo_rd_serializer.md
Name: fifo_rd_serializer

Overview:
- Read-side consumer for the byte FIFO: pops bytes when the FIFO is non-empty and shifts each one out on a single line, framed with a start bit and stop bit(s).
- Sits directly on the FIFO read port (rd, dout, nostock) and is the counterpart of the write-side producer.
- Provides a line-idle/busy indication and a sent-frame counter for debug and verification.

Parameters:
- DATA_W, 8, FIFO data width and number of data bits per frame.
- CLKS_PER_BIT, 4, clk cycles per serial bit; must be ≥1.
- STOP_BITS, 1, number of stop bits, 1 or 2.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  allows new pops; sampled only in IDLE and at frame end.
- nostock  input  1  FIFO empty flag.
- dout  input  DATA_W  FIFO read data; valid the cycle after rd=1.
- rd  output  1  FIFO pop strobe; one cycle wide.
- txd  output  1  serial line; idle high.
- busy  output  1  high from the POP cycle until the last stop bit ends.
- frame_cnt  output  16  completed frames; wraps 0xFFFF→0.

Behaviour:
- Reset values, applied asynchronously: rd=0, txd=1, busy=0, frame_cnt=0, state=IDLE, bit counter=0, clock-divider counter=0, shift register=0.
- FIFO contract: dout is registered, valid exactly one cycle after the rd cycle.
- rd is asserted only when nostock=0 in the same cycle. rd is never asserted on two consecutive cycles.
- States:
  - IDLE: txd=1, busy=0. If en && !nostock, go to POP.
  - POP: rd=1 for one cycle, busy=1. Go to CAP.
  - CAP: shift register <= dout, divider counter=0. Go to START.
  - START: txd=0 for CLKS_PER_BIT cycles. Go to DATA.
  - DATA: txd=shreg[0], LSB first. Each bit lasts CLKS_PER_BIT cycles. At each bit end the register shifts right and the bit counter increments. After DATA_W bits, go to STOP.
  - STOP: txd=1 for STOP_BITS*CLKS_PER_BIT cycles. On the final cycle, frame_cnt increments.
    - If en && !nostock on that final cycle, go to POP (back-to-back frames).
    - Otherwise go to IDLE.
- Latency: rd in cycle N. The start-bit low level appears on txd in cycle N+2.
- Frame length: (1 + DATA_W + STOP_BITS) * CLKS_PER_BIT cycles, plus 2 cycles of POP/CAP overhead.
  - Back-to-back gap between stop-bit end and the next start bit is exactly 2 cycles of txd=1.
- en deasserted mid-frame: the current frame completes unchanged. No further pop occurs.
- nostock rising during a frame has no effect; it is only sampled in IDLE and on the final STOP cycle.
- rst asserted mid-frame: txd returns to 1 immediately, the frame is dropped and not counted, and the popped byte is lost.
- txd, rd and busy are registered outputs; no combinational path from inputs to outputs.
- Divider counter width: $clog2(CLKS_PER_BIT+1). Bit counter width: $clog2(DATA_W+1).

Decomposition:
- Shared package fifo_pkg holds:
  - state enum ser_state_t: IDLE, POP, CAP, START, DATA, STOP.
  - FIFO_DATA_W=8 and FIFO_DEPTH=16, shared with the FIFO and the producer.
- One natural sub-module, bit_tick_gen. It takes CLKS_PER_BIT, clears on frame start, and emits a one-cycle tick at each bit boundary. The FSM stays in fifo_rd_serializer.

Test Plan:
- Reset, then hold nostock=1 and en=1 for 100 cycles → rd never 1, txd=1, busy=0, frame_cnt=0.
- Load one byte 0xA5 into the FIFO, CLKS_PER_BIT=4 → one rd pulse. Two cycles later txd outputs 0, then 1,0,1,0,0,1,0,1, each 4 cycles, then 1 for 4 cycles. frame_cnt=1, FIFO empty.
- Load 3 bytes 0x01, 0xFF, 0x3C with en=1 → three frames with exactly 2 idle-high cycles between stop and start. Decoded bytes match in order. frame_cnt=3. 3 rd pulses total.
- Deassert en during the DATA bits of byte 0x55 with 2 bytes queued → 0x55 frame completes. No rd afterwards, second byte remains in the FIFO. Re-assert en → it is sent.
- Assert rst during bit 3 of frame 0x96 → txd=1 in the same cycle, busy=0, frame_cnt=0. After rst release with the FIFO non-empty, the next frame is a clean full frame.
- Run with STOP_BITS=2 and frame_cnt preloaded via 65536 frames (or force) → stop period is 8 cycles and frame_cnt wraps to 0.
